// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern, overlap/non-overlap matching,
// Mealy or Moore output timing and a saturating match counter.
module seq_detector_param #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b001,
    parameter bit                 OVERLAP = 1'b1,
    parameter bit                 MOORE   = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               inp,
    input  logic               pat_ld,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               det,
    output logic [CNT_W-1:0]   cnt
);

    localparam int                FILL_W   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_LEN-1:0] r_pat;
    logic [PAT_LEN-2:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_det_q;

    logic [PAT_LEN-1:0] w_window;
    logic               w_hit;

    // Window is the stored history plus the bit arriving this cycle (newest at LSB).
    assign w_window = {r_hist, inp};
    assign w_hit    = en & ~pat_ld & ~rst & (r_fill == FILL_MAX) & (w_window == r_pat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat   <= PATTERN;
            r_hist  <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_det_q <= 1'b0;
        end else begin
            if (pat_ld) begin
                r_pat  <= pat_in;
                r_fill <= '0;
            end else if (en) begin
                r_hist <= w_window[PAT_LEN-2:0];
                // Non-overlapping mode restarts the history so the next match needs fresh bits.
                if (!OVERLAP && w_hit) begin
                    r_fill <= '0;
                end else if (r_fill != FILL_MAX) begin
                    r_fill <= r_fill + 1'b1;
                end
            end

            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_hit && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_det_q <= w_hit;
        end
    end

    assign det = MOORE ? r_det_q : w_hit;
    assign cnt = r_cnt;

endmodule
